// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the DMA channel priority arbiter.
package dma_arb_pkg;

   localparam int unsigned NUM_CH_DEFAULT = 4;
   localparam int unsigned CH_W_DEFAULT   = $clog2(NUM_CH_DEFAULT);

   typedef logic [CH_W_DEFAULT-1:0] chan_t;

   typedef enum logic [1:0] {
      IDLE,
      REQUEST,
      GRANTED,
      RELEASE
   } arbState_t;

   localparam logic PRIO_FIXED    = 1'b0;
   localparam logic PRIO_ROTATING = 1'b1;

endpackage

// File: rtl/dma_priority_resolver.sv
// Combinational winner selection: fixed (lowest index) or rotating from lastSrv+1.
module dma_priority_resolver
   import dma_arb_pkg::*;
#(
   parameter  int unsigned NUM_CH = NUM_CH_DEFAULT,
   localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   lastSrv,
   input  logic              priorityType,
   output logic [CH_W-1:0]   winner,
   output logic              anyReq
);

   logic [CH_W-1:0] idx;
   logic            found;

   assign anyReq = |req;

   // Index wraps naturally because NUM_CH is a power of two.
   always_comb begin
      winner = '0;
      idx    = '0;
      found  = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = (priorityType == PRIO_ROTATING) ? CH_W'(lastSrv + CH_W'(i + 1)) : CH_W'(i);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DREQ conditioning, priority resolution and HRQ/HLDA hold handshake for an 8237-style DMA.
// Optional software request register enabled by DMA_SW_REQUEST_EN.
module dma_priority_arbiter
   import dma_arb_pkg::*;
#(
   parameter  int unsigned NUM_CH = NUM_CH_DEFAULT,
   localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [NUM_CH-1:0] DREQ,
   input  logic              HLDA,
   input  logic [NUM_CH-1:0] maskBits,
   input  logic              dreqActiveLow,
   input  logic              priorityType,
   input  logic              controllerDisable,
   input  logic              serviceEnd,
`ifdef DMA_SW_REQUEST_EN
   input  logic              swReqWrite,
   input  logic [CH_W:0]     swReqData,
`endif
   output logic              HRQ,
   output logic [NUM_CH-1:0] DACK,
   output logic              grantValid,
   output logic [CH_W-1:0]   grantChannel
);

   arbState_t         state;
   logic [NUM_CH-1:0] eff_req;
   logic [NUM_CH-1:0] req_reg;
   logic [CH_W-1:0]   last_srv;
   logic [CH_W-1:0]   winner;
   logic              any_req;

`ifdef DMA_SW_REQUEST_EN
   logic [NUM_CH-1:0] sw_req;

   // Software requests persist until written clear or the channel finishes service.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         sw_req <= '0;
      end else begin
         if (swReqWrite)
            sw_req[swReqData[CH_W-1:0]] <= swReqData[CH_W];
         if (state == GRANTED && serviceEnd)
            sw_req[grantChannel] <= 1'b0;
      end
   end
`endif

   always_comb begin
      eff_req = (DREQ ^ {NUM_CH{dreqActiveLow}}) & ~maskBits;
`ifdef DMA_SW_REQUEST_EN
      eff_req = eff_req | sw_req;
`endif
   end

   dma_priority_resolver #(
      .NUM_CH(NUM_CH)
   ) u_resolver (
      .req         (req_reg),
      .lastSrv     (last_srv),
      .priorityType(priorityType),
      .winner      (winner),
      .anyReq      (any_req)
   );

   // Hold handshake; the winner is latched on HLDA and frozen until release.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state        <= IDLE;
         HRQ          <= 1'b0;
         DACK         <= '0;
         grantValid   <= 1'b0;
         grantChannel <= '0;
         last_srv     <= CH_W'(NUM_CH - 1);
         req_reg      <= '0;
      end else begin
         req_reg <= eff_req;
         case (state)
            IDLE: begin
               if (any_req && !controllerDisable) begin
                  state <= REQUEST;
                  HRQ   <= 1'b1;
               end
            end
            REQUEST: begin
               if (!any_req || controllerDisable) begin
                  state <= RELEASE;
                  HRQ   <= 1'b0;
               end else if (HLDA) begin
                  state        <= GRANTED;
                  DACK         <= NUM_CH'(1) << winner;
                  grantValid   <= 1'b1;
                  grantChannel <= winner;
               end
            end
            GRANTED: begin
               // serviceEnd wins over a simultaneous HLDA drop so the pointer still advances.
               if (serviceEnd || !HLDA) begin
                  state      <= RELEASE;
                  HRQ        <= 1'b0;
                  DACK       <= '0;
                  grantValid <= 1'b0;
                  if (serviceEnd && priorityType == PRIO_ROTATING)
                     last_srv <= grantChannel;
               end
            end
            RELEASE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
- Channel request/priority stage directly upstream of the DMA timing-and-control FSM in the 4-channel 8237-style controller.
- Samples DREQ, applies mask, polarity and disable controls, and resolves fixed or rotating priority.
- Runs the HRQ/HLDA hold handshake and drives a one-hot DACK plus the granted channel number to timing/control.
- Holds the grant until timing/control signals end of service, then releases.

Parameters:
- NUM_CH, 4, number of DMA channels; must be a power of two ≥2.
- CH_W, $clog2(NUM_CH), channel index width; derived, not overridden.

Ports:
- CLK  input  1  system clock, all state on posedge
- RESET  input  1  synchronous active-high reset
- DREQ  input  NUM_CH  raw channel DMA requests
- HLDA  input  1  hold acknowledge from CPU
- maskBits  input  NUM_CH  per-channel mask from mask register; 1 = masked
- dreqActiveLow  input  1  command reg DREQ sense; 0 = active high
- priorityType  input  1  command reg; 0 = fixed, 1 = rotating
- controllerDisable  input  1  command reg controller disable
- serviceEnd  input  1  single-cycle pulse from timing/control: current channel service complete
- HRQ  output  1  hold request to CPU
- DACK  output  NUM_CH  one-hot acknowledge, active high at this boundary
- grantValid  output  1  grant active; timing/control may start cycles
- grantChannel  output  CH_W  index of granted channel

Behaviour:
- Effective request: effReq = (DREQ ^ {NUM_CH{dreqActiveLow}}) & ~maskBits, registered each cycle into reqReg.
- FSM states: IDLE, REQUEST, GRANTED, RELEASE; all outputs registered.
- Reset (synchronous, highest priority, also mid-operation):
  - state = IDLE; HRQ = 0; DACK = 0; grantValid = 0; grantChannel = 0.
  - rotation pointer lastSrv = NUM_CH-1, so channel 0 is highest.
  - No grant survives reset.
- IDLE:
  - If |effReq && !controllerDisable: go to REQUEST; HRQ = 1 next cycle.
  - Otherwise stay.
- REQUEST:
  - HRQ held at 1.
  - If HLDA = 1: resolve winner from the current effReq and go to GRANTED. DACK[winner], grantValid and grantChannel are set on the same edge.
  - If effReq becomes 0 or controllerDisable rises before HLDA: go to RELEASE.
- Latency: DREQ 0011 sampled at edge t with HLDA high → HRQ = 1 at t+1, DACK = 0001 at t+2.
- Resolution:
  - Fixed priority: lowest index wins.
  - Rotating priority: search starts at lastSrv+1 (mod NUM_CH) upward with wrap-around; first set bit wins.
  - The winner is frozen for the whole grant.
- GRANTED:
  - HRQ, DACK and grantChannel are held stable.
  - Later DREQ, mask or priority changes do not re-arbitrate.
  - Deassertion of the granted DREQ is ignored; timing/control decides end of service.
  - serviceEnd = 1: go to RELEASE. If priorityType = 1, lastSrv = grantChannel on the same edge; fixed mode leaves lastSrv unchanged.
  - HLDA = 0 (CPU revoked): go to RELEASE; lastSrv unchanged.
  - serviceEnd and HLDA drop in the same cycle: treat as serviceEnd (pointer updates).
- RELEASE:
  - Exactly one cycle with HRQ = 0, DACK = 0, grantValid = 0.
  - Then IDLE. Re-request is possible no earlier than the following edge.
- priorityType changes take effect at the next resolution only. Switching to fixed does not reset lastSrv.
- serviceEnd outside GRANTED is ignored.
- Invariants: DACK is zero or one-hot at all times. DACK ≠ 0 implies HRQ = 1 and grantValid = 1.

Optional Feature:
- Macro DMA_SW_REQUEST_EN.
- Defined:
  - Adds ports swReqWrite (input, 1) and swReqData (input, CH_W+1). swReqData[CH_W] = set/clear; swReqData[CH_W-1:0] = channel.
  - Request register swReqReg (NUM_CH bits, reset 0) is written on swReqWrite.
  - effReq |= swReqReg. Software requests bypass maskBits and dreqActiveLow.
  - swReqReg bit of grantChannel clears on serviceEnd.
- Undefined: no extra ports; software requests do not exist.

Decomposition:
- Package dma_arb_pkg:
  - arbState_t enum (IDLE, REQUEST, GRANTED, RELEASE)
  - NUM_CH_DEFAULT constant
  - chan_t typedef
  - PRIO_FIXED / PRIO_ROTATING constants
- Sub-module dma_priority_resolver: combinational; inputs req, lastSrv, priorityType; outputs winner and anyReq. Reused by the checker for reference-model priority.

Test Plan:
1. RESET high 2 cycles, DREQ = 1111 → HRQ = 0, DACK = 0000, grantValid = 0 throughout; first grant after release is channel 0.
2. Fixed, HLDA = 1, DREQ = 0011 → HRQ = 1 at t+1, DACK = 0001, grantChannel = 0 at t+2; serviceEnd → RELEASE cycle with DACK = 0000, then DACK = 0001 again.
3. Rotating, DREQ = 1111 held, serviceEnd on each grant → DACK sequence 0001, 0010, 0100, 1000, 0001.
4. maskBits = 0001, DREQ = 0001 → HRQ stays 0. DREQ = 0011 → DACK = 0010. dreqActiveLow = 1 with DREQ = 1110 → DACK = 0001.
5. Abort and reset: in GRANTED on channel 2, drop HLDA → DACK = 0000, HRQ = 0 next cycle, lastSrv unchanged. Separate run: RESET mid-grant → all outputs 0 next edge.
6. DMA_SW_REQUEST_EN, DREQ = 0000, maskBits = 1111, swReqData = 110 written → DACK = 0100. After serviceEnd, swReqReg = 0000 and HRQ stays 0.
